// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter among four byte requesters.
// Define UART_ARB_TIMEOUT_EN to abort a frame whose Tx_BUSY never rises.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arb_en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  input  logic        Tx_BUSY,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        arb_busy,
  output logic        tx_err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t      state, state_n;
  logic [3:0]  grant_n, ack_n;
  logic [7:0]  data_n;
  logic        wr_n, err_n;
  logic [1:0]  last, last_n;
  logic [1:0]  win, idx;
  logic        found;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // Search starts one past the last winner and wraps mod 4.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ack_n   = '0;
    wr_n    = 1'b0;
    data_n  = Tx_DATA;
    last_n  = last;
    err_n   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (arb_en && |req && !Tx_BUSY) begin
          state_n = WRITE;
          grant_n = 4'b0001 << win;
          ack_n   = 4'b0001 << win;
          wr_n    = 1'b1;
          data_n  = req_data[8*win +: 8];
          last_n  = win;
        end
      end
      WRITE: begin
        state_n = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      WAIT_HI: begin
        if (Tx_BUSY) begin
          state_n = WAIT_LO;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          grant_n = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      WAIT_LO: begin
        if (!Tx_BUSY) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= '0;
      Tx_WR    <= 1'b0;
      Tx_DATA  <= 8'h00;
      last     <= 2'd3;
      arb_busy <= 1'b0;
      tx_err   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ack      <= ack_n;
      Tx_WR    <= wr_n;
      Tx_DATA  <= data_n;
      last     <= last_n;
      arb_busy <= (state_n != IDLE);
      tx_err   <= err_n;
`ifdef UART_ARB_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter among four byte requesters using round-robin arbitration. Drives the transmitter's Tx_DATA/Tx_WR, tracks Tx_BUSY through each frame, and returns a one-cycle ack to the granted requester. Sits between the requester logic (drivers, status reporters, loopback test sources) and uart_transmitter, replacing the single hardwired transmitter driver in the top level.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in WAIT_HI for Tx_BUSY to rise (used only with UART_ARB_TIMEOUT_EN); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; already synchronized upstream
arb_en  input  1  1 = new grants allowed; 0 = finish current frame, grant nothing new
req  input  4  per-requester level request; held until ack
req_data  input  32  requester i byte at bits [8i+7:8i]; stable while req[i]=1
ack  output  4  one-hot, 1-cycle pulse: byte of requester i handed to transmitter
grant  output  4  one-hot owner of transmitter, WRITE through WAIT_LO; 0 otherwise
Tx_BUSY  input  1  from uart_transmitter
Tx_DATA  output  8  to uart_transmitter, registered
Tx_WR  output  1  to uart_transmitter, 1-cycle pulse
arb_busy  output  1  1 whenever state != IDLE
tx_err  output  1  1-cycle pulse on busy-rise timeout (0 without macro)

Behaviour:
- Reset (synchronous, any state): state=IDLE, ack=0, grant=0, Tx_DATA=8'h00, Tx_WR=0, arb_busy=0, tx_err=0, last pointer=2'd3 (requester 0 wins first), timeout counter=0.
- States: IDLE, WRITE, WAIT_HI, WAIT_LO. All outputs registered.
- IDLE: if arb_en && |req && !Tx_BUSY: winner = first i with req[i]=1 searching last+1, last+2, ... mod 4. Latch Tx_DATA=req_data[winner], grant=onehot(winner), last=winner; go WRITE. Otherwise stay in IDLE.
- WRITE (exactly 1 cycle): Tx_WR=1, ack[winner]=1; go WAIT_HI. Latency: req sampled in IDLE at cycle n -> Tx_WR and ack high at cycle n+1.
- WAIT_HI: Tx_WR=0, ack=0; on Tx_BUSY=1 go WAIT_LO.
- WAIT_LO: on Tx_BUSY=0 go IDLE and clear grant. Next grant is possible in the following cycle, so back-to-back frames have 1 IDLE cycle between them.
- Tx_DATA holds its value from the latch until the next grant; it never changes while grant != 0.
- A requester that keeps req high after ack is re-queued. Its byte is taken at its next round-robin turn. Requesters must update req_data on the cycle after ack.
- Requests that drop before grant are ignored. A req change while granted has no effect on the current frame.
- arb_en falling mid-frame: the frame completes normally; the arbiter then stays in IDLE.
- Tx_BUSY=1 in IDLE (external or stale busy): no grant.
- Simultaneous requests: strict rotation. With all four held high, grants go 0,1,2,3,0...
- Pointer wrap: last=3 -> search starts at 0.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: counter runs in WAIT_HI. If Tx_BUSY is still 0 after TIMEOUT_CYCLES cycles in WAIT_HI, go IDLE, clear grant, and pulse tx_err for 1 cycle. The ack already given is not retracted. The counter clears on entering WAIT_HI.
- Undefined: no counter; WAIT_HI waits indefinitely; tx_err is constant 0.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, Tx_BUSY model rises 1 cycle after Tx_WR and stays high 10 cycles -> Tx_WR and ack=4'b0100 one cycle after req sampled; Tx_DATA=8'hA5; grant=4'b0100 until busy falls; IDLE after.
- Rotation: all req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13 -> four consecutive frames with Tx_DATA 10,11,12,13, then 10 again; exactly one ack per frame.
- Pointer fairness: after requester 2 is served, req=4'b0101 -> requester 0 is granted before requester 2.
- arb_en gating: start a frame, drop arb_en during WAIT_LO -> frame completes with a normal WAIT_LO exit; no further Tx_WR while arb_en=0 despite req=4'b0001; Tx_WR occurs 1 cycle after arb_en returns to 1.
- Reset mid-frame: assert reset in WAIT_LO with Tx_BUSY=1 -> next cycle all outputs 0 and Tx_DATA=00; first grant after reset with req=4'b1111 goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): Tx_BUSY held 0 after Tx_WR -> tx_err pulses after 16 WAIT_HI cycles; grant=0; arbiter resumes on the next request.
